// File: rtl/wb_pkg.sv
// Shared definitions for the write-back select stage: fixed source map, FSM state
// encoding and the saturating wait-counter increment.
package wb_pkg;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LINK = 2;
  localparam int SRC_IN   = 3;

  localparam int WAIT_CNT_WIDTH = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_IN = 1'b1
  } wb_state_e;

  function automatic logic [WAIT_CNT_WIDTH-1:0] sat_inc(input logic [WAIT_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + WAIT_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/wb_source_mux.sv
// Combinational NUM_SRC:1 selector over a flattened source bus.
// in_range_o is low when sel_i does not address any implemented source.
module wb_source_mux
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
  input  logic [SEL_WIDTH-1:0]          sel_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          in_range_o
);

  logic [DATA_WIDTH-1:0] src_words [NUM_SRC];
  logic [NUM_SRC-1:0]    hit;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_words[gi] = src_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign hit[gi]       = (sel_i == SEL_WIDTH'(gi));
  end

  // One-hot hit vector: at most one source matches, so a priority loop is a plain mux.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hit[k]) begin
        data_o = src_words[k];
      end
    end
  end

  assign in_range_o = |hit;

endmodule

// File: rtl/writeback_select_stage.sv
// Registered write-back source selector. The external-input source stalls the core
// until the input device presents a word, then writes it like any other source.
module writeback_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int PC_INCR    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [SEL_WIDTH-1:0]          req_sel,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [DATA_WIDTH-1:0]         pc_current,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ack,
  output logic                          stall,
  output logic                          wb_valid,
  output logic [ADDR_WIDTH-1:0]         wb_addr,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic [15:0]                   wait_cycles
);

  wb_state_e                 state_q, state_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [ADDR_WIDTH-1:0]     wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_q, wait_d;

  logic [DATA_WIDTH-1:0] mux_data;
  logic [DATA_WIDTH-1:0] link_data;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  mux_in_range;
  logic                  sel_is_in;
  logic                  sel_is_link;

  wb_source_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SRC    (NUM_SRC),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .src_data_i (src_data),
    .sel_i      (req_sel),
    .data_o     (mux_data),
    .in_range_o (mux_in_range)
  );

  // Link value wraps at DATA_WIDTH; the src_data slice for the link source is ignored.
  assign link_data   = pc_current + DATA_WIDTH'(PC_INCR);
  assign sel_is_in   = (req_sel == SEL_WIDTH'(SRC_IN));
  assign sel_is_link = (req_sel == SEL_WIDTH'(SRC_LINK));
  assign sel_data    = sel_is_link ? link_data : mux_data;

  always_comb begin
    state_d    = state_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wait_d     = wait_q;
    in_ack     = 1'b0;
    stall      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (sel_is_in) begin
            wait_d = '0;
            if (in_valid) begin
              in_ack     = 1'b1;
              wb_valid_d = 1'b1;
              wb_addr_d  = req_addr;
              wb_data_d  = in_data;
            end else begin
              stall   = 1'b1;
              state_d = WAIT_IN;
            end
          end else if (mux_in_range) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = req_addr;
            wb_data_d  = sel_data;
          end
        end
      end
      WAIT_IN: begin
        // Every WAIT_IN cycle counts, including the one in which the word arrives.
        wait_d = sat_inc(wait_q);
        if (in_valid) begin
          in_ack     = 1'b1;
          wb_valid_d = 1'b1;
          wb_addr_d  = req_addr;
          wb_data_d  = in_data;
          state_d    = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reset edge abandons any handshake: the input word must not be consumed.
    if (reset) begin
      in_ack = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wait_q     <= wait_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign wait_cycles = wait_q;

endmodule
